// File: rtl/filter_pkg.sv
// Shared types for the pot conditioner: channel/sample widths and the
// output handshake state machine encoding.
package filter_pkg;

    localparam int NCHAN  = 2;
    localparam int ADC_W  = 10;
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [ADC_W-1:0]  adc_word_t;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } out_state_e;

    localparam adc_word_t ADC_MAX = '1;

    function automatic chan_t next_chan(input chan_t c);
        if (c == chan_t'(NCHAN - 1)) begin
            return '0;
        end
        return c + chan_t'(1);
    endfunction

    // Audio taper: square law normalised back to ADC_W bits.
    function automatic adc_word_t audio_taper(input adc_word_t x);
        logic [2*ADC_W-1:0] sq;
        sq = {{ADC_W{1'b0}}, x} * {{ADC_W{1'b0}}, x};
        return adc_word_t'(sq >> ADC_W);
    endfunction

endpackage

// File: rtl/pot_ema.sv
// One pot channel: two-flop synchroniser, exponential moving average and
// hysteresis gate producing a pending flag plus the candidate value.
module pot_ema
    import filter_pkg::*;
#(
    parameter int AVG_SHIFT = 3,
    parameter int HYST      = 4
) (
    input  logic      CLK50,
    input  logic      reset,
    input  adc_word_t adc_in,
    input  logic      tick,
    input  logic      grant,
    output logic      pending,
    output adc_word_t cand
);

    localparam int ACC_W = ADC_W + AVG_SHIFT;
    typedef logic [ACC_W-1:0] acc_t;

    adc_word_t sync1_q, sync1_d;
    adc_word_t sync2_q, sync2_d;
    acc_t      acc_q, acc_d;
    logic      primed_q, primed_d;
    logic      cmp_q, cmp_d;
    logic      force_q, force_d;
    logic      pending_q, pending_d;
    adc_word_t cand_q, cand_d;
    adc_word_t last_sent_q, last_sent_d;

    adc_word_t avg;
    adc_word_t diff;
    logic      hyst_hit;
    logic      endpoint;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path leaves it unassigned (no latch).
        sync1_d     = adc_in;
        sync2_d     = sync1_q;
        acc_d       = acc_q;
        primed_d    = primed_q;
        cmp_d       = tick;
        force_d     = tick & ~primed_q;
        pending_d   = pending_q;
        cand_d      = cand_q;
        last_sent_d = last_sent_q;

        // Subtracting the old average first keeps acc inside ACC_W bits.
        if (tick) begin
            primed_d = 1'b1;
            if (!primed_q) begin
                acc_d = acc_t'(sync2_q) << AVG_SHIFT;
            end else begin
                acc_d = (acc_q - (acc_q >> AVG_SHIFT)) + acc_t'(sync2_q);
            end
        end

        avg      = adc_word_t'(acc_q >> AVG_SHIFT);
        diff     = (avg >= last_sent_q) ? (avg - last_sent_q) : (last_sent_q - avg);
        hyst_hit = (int'(diff) >= HYST);
        endpoint = ((avg == '0) || (avg == ADC_MAX)) && (avg != last_sent_q);

        if (grant) begin
            pending_d   = 1'b0;
            last_sent_d = cand_q;
        end
        // A fresh compare wins over a same-cycle grant, so the newer value is kept.
        if (cmp_q && (force_q || hyst_hit || endpoint)) begin
            pending_d = 1'b1;
            cand_d    = avg;
        end
    end

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            acc_q       <= '0;
            primed_q    <= 1'b0;
            cmp_q       <= 1'b0;
            force_q     <= 1'b0;
            pending_q   <= 1'b0;
            cand_q      <= '0;
            last_sent_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            acc_q       <= acc_d;
            primed_q    <= primed_d;
            cmp_q       <= cmp_d;
            force_q     <= force_d;
            pending_q   <= pending_d;
            cand_q      <= cand_d;
            last_sent_q <= last_sent_d;
        end
    end

    assign pending = pending_q;
    assign cand    = cand_q;

endmodule

// File: rtl/pot_conditioner.sv
// Pot conditioner top: sample tick, round-robin arbiter and valid/ready output.
// Define POT_CONDITIONER_AUDIO_TAPER_EN for square-law (audio taper) param_data.
module pot_conditioner
    import filter_pkg::*;
#(
    parameter int AVG_SHIFT = 3,
    parameter int HYST      = 4,
    parameter int TICK_DIV  = 50000
) (
    input  logic                  CLK50,
    input  logic                  reset,
    input  adc_word_t [NCHAN-1:0] adc_in,
    output adc_word_t             param_data,
    output chan_t                 param_chan,
    output logic                  param_valid,
    input  logic                  param_ready
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    out_state_e state_q, state_d;
    adc_word_t  data_q, data_d;
    chan_t      chan_q, chan_d;
    chan_t      rr_ptr_q, rr_ptr_d;

    logic [NCHAN-1:0] pending;
    logic [NCHAN-1:0] grant;
    adc_word_t        cand [NCHAN];

    logic      arb_found;
    chan_t     arb_sel;
    chan_t     arb_idx;
    logic      do_grant;
    adc_word_t grant_data;

    always_comb begin
        tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        pot_ema #(
            .AVG_SHIFT (AVG_SHIFT),
            .HYST      (HYST)
        ) u_ema (
            .CLK50   (CLK50),
            .reset   (reset),
            .adc_in  (adc_in[g]),
            .tick    (tick),
            .grant   (grant[g]),
            .pending (pending[g]),
            .cand    (cand[g])
        );
    end

    // Search starts at rr_ptr, the channel after the last one granted.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = rr_ptr_q;
        arb_idx   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            arb_idx = chan_t'((int'(rr_ptr_q) + i) % NCHAN);
            if (!arb_found && pending[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    always_comb begin
`ifdef POT_CONDITIONER_AUDIO_TAPER_EN
        grant_data = audio_taper(cand[arb_sel]);
`else
        grant_data = cand[arb_sel];
`endif
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rr_ptr_d = rr_ptr_q;
        grant    = '0;
        do_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_grant = arb_found;
            end
            ST_HOLD: begin
                if (param_ready) begin
                    do_grant = arb_found;
                    if (!arb_found) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_grant) begin
            grant[arb_sel] = 1'b1;
            data_d         = grant_data;
            chan_d         = arb_sel;
            rr_ptr_d       = next_chan(arb_sel);
            state_d        = ST_HOLD;
        end
    end

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            data_q     <= '0;
            chan_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Valid follows the state register directly, so reset clears it at once.
    assign param_valid = (state_q == ST_HOLD);
    assign param_data  = data_q;
    assign param_chan  = chan_q;

endmodule

// File: tb/tb_pot_conditioner.sv
// Directed bench for pot_conditioner with a short sample tick (TICK_DIV=4).
// Expected values are hand-derived EMA results; taper applied when enabled.
module tb_pot_conditioner;
    import filter_pkg::*;

    localparam int TDIV = 4;
    localparam int NV   = 11;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    adc_word_t [NCHAN-1:0] adc_in;
    adc_word_t             param_data;
    chan_t                 param_chan;
    logic                  param_valid;
    logic                  param_ready;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc;
    int hs_n   [NCHAN] = '{default: 0};
    int last_d [NCHAN] = '{default: 0};

    typedef struct {
        int x0;
        int x1;
        int n0;
        int d0;
        int n1;
        int d1;
    } vec_t;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    pot_conditioner #(
        .AVG_SHIFT (3),
        .HYST      (4),
        .TICK_DIV  (TDIV)
    ) dut (
        .CLK50       (clk),
        .reset       (rst),
        .adc_in      (adc_in),
        .param_data  (param_data),
        .param_chan  (param_chan),
        .param_valid (param_valid),
        .param_ready (param_ready)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (!rst && param_valid && param_ready) begin
            hs_n[param_chan]   <= hs_n[param_chan] + 1;
            last_d[param_chan] <= int'(param_data);
        end
    end

    function automatic int shape(input int x);
`ifdef POT_CONDITIONER_AUDIO_TAPER_EN
        return (x * x) >> ADC_W;
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    task automatic wait_phase(input int p);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((cyc % TDIV) != p && g < 4 * TDIV);
        if ((cyc % TDIV) != p) check("wait_phase", cyc % TDIV, p);
    endtask

    task automatic expect_out(input string name, input int v, input int ch, input int d);
        check({name, "_valid"}, int'(param_valid), v);
        if (v != 0) begin
            check({name, "_chan"}, int'(param_chan), ch);
            check({name, "_data"}, int'(param_data), shape(d));
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst         = 1'b1;
        param_ready = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int b0, b1;

        // ch0 settled at 512 then ramp to 520, then decay toward 0 with a ch1 step.
        tbl[0]  = '{520, 300, 0, 0,   0, 0};
        tbl[1]  = '{520, 300, 0, 0,   0, 0};
        tbl[2]  = '{520, 300, 0, 0,   0, 0};
        tbl[3]  = '{520, 300, 0, 0,   0, 0};
        tbl[4]  = '{520, 300, 1, 516, 0, 0};
        tbl[5]  = '{0,   300, 1, 451, 0, 0};
        tbl[6]  = '{0,   300, 1, 395, 0, 0};
        tbl[7]  = '{0,   300, 1, 345, 0, 0};
        tbl[8]  = '{0,   300, 1, 302, 0, 0};
        tbl[9]  = '{0,   400, 1, 265, 1, 312};
        tbl[10] = '{0,   400, 1, 231, 1, 323};

        adc_in[0]   = adc_word_t'(512);
        adc_in[1]   = adc_word_t'(300);
        param_ready = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(param_valid), 0);
        check("rst_data",  int'(param_data),  0);
        check("rst_chan",  int'(param_chan),  0);
        rst = 1'b0;

        // Prime: tick at edge 4, valid visible after edge 6, back-to-back ch1.
        wait_cyc(5);
        expect_out("prime_early", 0, 0, 0);
        wait_cyc(6);
        expect_out("prime_ch0", 1, 0, 512);
        wait_cyc(7);
        expect_out("prime_ch1", 1, 1, 300);
        wait_cyc(8);
        expect_out("prime_done", 0, 0, 0);

        b0 = hs_n[0];
        b1 = hs_n[1];
        for (int i = 0; i <= NV; i++) begin
            wait_phase(1);
            if (i < NV) begin
                adc_in[0] = adc_word_t'(tbl[i].x0);
                adc_in[1] = adc_word_t'(tbl[i].x1);
            end
            wait_phase(0);
            if (i > 0) begin
                check($sformatf("vec%0d_n0", i - 1), hs_n[0] - b0, tbl[i-1].n0);
                check($sformatf("vec%0d_n1", i - 1), hs_n[1] - b1, tbl[i-1].n1);
                if (tbl[i-1].n0 > 0) check($sformatf("vec%0d_d0", i - 1), last_d[0], shape(tbl[i-1].d0));
                if (tbl[i-1].n1 > 0) check($sformatf("vec%0d_d1", i - 1), last_d[1], shape(tbl[i-1].d1));
                b0 = hs_n[0];
                b1 = hs_n[1];
            end
        end

        // Lower endpoint must be reached exactly, then the output goes quiet.
        repeat (80 * TDIV) @(negedge clk);
        check("zero_final", last_d[0], shape(0));
        b0 = hs_n[0];
        b1 = hs_n[1];
        repeat (10 * TDIV) @(negedge clk);
        check("zero_quiet0", hs_n[0] - b0, 0);
        check("zero_quiet1", hs_n[1] - b1, 0);

        adc_in[0] = adc_word_t'(1023);
        repeat (80 * TDIV) @(negedge clk);
        check("top_final", last_d[0], shape(1023));
        b0 = hs_n[0];
        b1 = hs_n[1];
        repeat (10 * TDIV) @(negedge clk);
        check("top_quiet0", hs_n[0] - b0, 0);
        check("top_quiet1", hs_n[1] - b1, 0);

        // Back-pressure: ch0 held for 20 cycles, ch1 follows once ready rises.
        do_reset(1'b0);
        b0 = hs_n[0];
        b1 = hs_n[1];
        wait_cyc(6);
        expect_out("hold_start", 1, 0, 1023);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            expect_out("hold", 1, 0, 1023);
        end
        param_ready = 1'b1;
        @(negedge clk);
        expect_out("hold_next", 1, 1, 400);
        @(negedge clk);
        expect_out("hold_done", 0, 0, 0);
        repeat (12) @(negedge clk);
        check("hold_cnt0", hs_n[0] - b0, 1);
        check("hold_cnt1", hs_n[1] - b1, 1);

        // Reset in the middle of a held update discards it; prime re-emits both.
        do_reset(1'b0);
        wait_cyc(6);
        expect_out("mid_hold", 1, 0, 1023);
        @(negedge clk);
        b0 = hs_n[0];
        b1 = hs_n[1];
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(param_valid), 0);
        check("mid_rst_data",  int'(param_data),  0);
        check("mid_rst_chan",  int'(param_chan),  0);
        repeat (2) @(negedge clk);
        param_ready = 1'b1;
        rst         = 1'b0;
        wait_cyc(6);
        expect_out("reprime_ch0", 1, 0, 1023);
        wait_cyc(7);
        expect_out("reprime_ch1", 1, 1, 400);
        wait_cyc(8);
        expect_out("reprime_done", 0, 0, 0);
        check("reprime_cnt0", hs_n[0] - b0, 1);
        check("reprime_cnt1", hs_n[1] - b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
